// File: rtl/full_adder_unit_if.sv
// Operand/result bundle for full_adder_unit: the master drives operands and the
// valid strobe, the slave returns combinational and registered results.
interface full_adder_unit_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic             in_valid;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             out_valid;

    modport master (
        output a, b, c, in_valid,
        input  sum, carry, sum_q, carry_q, out_valid
    );

    modport slave (
        input  a, b, c, in_valid,
        output sum, carry, sum_q, carry_q, out_valid
    );
endinterface

// File: rtl/full_adder_unit.sv
// Ripple-carry adder: zero-latency {carry, sum} = a + b + c, plus a one-cycle
// registered copy of the result qualified by out_valid.
module full_adder_unit #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    full_adder_unit_if.slave bus
);
    // One full-adder cell, returned as {carry_out, sum_bit}.
    function automatic logic [1:0] fa_cell(input logic a_i, input logic b_i, input logic k_i);
        logic p;
        p = a_i ^ b_i;
        return {(a_i & b_i) | (k_i & p), p ^ k_i};
    endfunction

    logic [WIDTH-1:0] sum_s;
    logic             carry_s;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             carry_d;
    logic             carry_q;
    logic             out_valid_d;
    logic             out_valid_q;

    // Carry chain rippling from bit 0 upwards, seeded by the carry-in.
    always_comb begin : ripple_chain
        logic       k_v;
        logic [1:0] cell_v;
        k_v    = bus.c;
        cell_v = 2'b00;
        sum_s  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cell_v   = fa_cell(bus.a[i], bus.b[i], k_v);
            sum_s[i] = cell_v[0];
            k_v      = cell_v[1];
        end
        carry_s = k_v;
    end

    // Capture a new result when in_valid is high, otherwise hold it and drop valid.
    always_comb begin
        sum_d       = sum_q;
        carry_d     = carry_q;
        out_valid_d = 1'b0;
        if (bus.in_valid) begin
            sum_d       = sum_s;
            carry_d     = carry_s;
            out_valid_d = 1'b1;
        end else begin
            sum_d       = sum_q;
            carry_d     = carry_q;
            out_valid_d = 1'b0;
        end
    end

    // Result register; reset discards any pending capture immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.sum       = sum_s;
    assign bus.carry     = carry_s;
    assign bus.sum_q     = sum_q;
    assign bus.carry_q   = carry_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_full_adder_unit.sv
// Self-checking bench for full_adder_unit at WIDTH 1, 4 and 8 against an
// arithmetic reference model plus hand-computed directed expectations.
module tb_full_adder_unit;
    localparam int W [3] = '{1, 4, 8};

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst_n;

    logic [63:0] in_a [3];
    logic [63:0] in_b [3];
    logic        in_c [3];
    logic        in_v [3];
    logic [64:0] dut_comb [3];
    logic [64:0] dut_reg [3];
    logic        dut_ov [3];
    logic [64:0] m_res [3];
    logic        m_v [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 if (clk_en) clk = ~clk;

    full_adder_unit_if #(.WIDTH(1)) if1 ();
    full_adder_unit_if #(.WIDTH(4)) if4 ();
    full_adder_unit_if #(.WIDTH(8)) if8 ();

    full_adder_unit #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    full_adder_unit #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    full_adder_unit #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

    assign if1.a = in_a[0][0:0];
    assign if1.b = in_b[0][0:0];
    assign if1.c = in_c[0];
    assign if1.in_valid = in_v[0];
    assign if4.a = in_a[1][3:0];
    assign if4.b = in_b[1][3:0];
    assign if4.c = in_c[1];
    assign if4.in_valid = in_v[1];
    assign if8.a = in_a[2][7:0];
    assign if8.b = in_b[2][7:0];
    assign if8.c = in_c[2];
    assign if8.in_valid = in_v[2];

    assign dut_comb[0] = 65'({if1.carry, if1.sum});
    assign dut_comb[1] = 65'({if4.carry, if4.sum});
    assign dut_comb[2] = 65'({if8.carry, if8.sum});
    assign dut_reg[0]  = 65'({if1.carry_q, if1.sum_q});
    assign dut_reg[1]  = 65'({if4.carry_q, if4.sum_q});
    assign dut_reg[2]  = 65'({if8.carry_q, if8.sum_q});
    assign dut_ov[0]   = if1.out_valid;
    assign dut_ov[1]   = if4.out_valid;
    assign dut_ov[2]   = if8.out_valid;

    function automatic logic [64:0] wmask(int w);
        return (65'd1 << w) - 65'd1;
    endfunction

    // Reference: plain integer addition of the width-truncated operands.
    function automatic logic [64:0] add_ref(int i);
        logic [64:0] m;
        m = wmask(W[i]);
        return (65'(in_a[i]) & m) + (65'(in_b[i]) & m) + 65'(in_c[i]);
    endfunction

    task automatic check(string name, logic [64:0] act, logic [64:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_all(string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s comb w%0d", tag, W[i]), dut_comb[i], add_ref(i));
            check($sformatf("%s reg w%0d", tag, W[i]), dut_reg[i], m_res[i]);
            check($sformatf("%s valid w%0d", tag, W[i]), 65'(dut_ov[i]), 65'(m_v[i]));
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin
            m_res[i] = 65'd0;
            m_v[i]   = 1'b0;
        end
    endtask

    // One clock: the model captures at the rising edge, outputs are compared at the falling edge.
    task automatic step(string tag);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (in_v[i]) begin
                m_res[i] = add_ref(i);
                m_v[i]   = 1'b1;
            end else begin
                m_v[i]   = 1'b0;
            end
        end
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic set_in(int i, logic [63:0] a, logic [63:0] b, logic c, logic v);
        in_a[i] = a;
        in_b[i] = b;
        in_c[i] = c;
        in_v[i] = v;
    endtask

    initial begin
        logic [7:0] tt_sum;
        logic [7:0] tt_carry;
        logic [2:0] abc;
        tt_sum   = 8'b1001_0110;
        tt_carry = 8'b1110_1000;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) set_in(i, 64'd0, 64'd0, 1'b0, 1'b0);
        clear_model();
        #1;
        check("reset reg w8", dut_reg[2], 65'd0);
        check("reset valid w8", 65'(dut_ov[2]), 65'd0);
        compare_all("reset");

        // Truth table on the 1-bit adder, reset held and no clock.
        for (int n = 0; n < 8; n++) begin
            abc = 3'(n);
            set_in(0, {63'd0, abc[2]}, {63'd0, abc[1]}, abc[0], 1'b0);
            #5;
            check($sformatf("truth %0d%0d%0d", abc[2], abc[1], abc[0]),
                  dut_comb[0], {63'd0, tt_carry[n], tt_sum[n]});
            #5;
        end
        compare_all("reset comb");

        // Release reset while the clock is low, then capture 1+0+1 on the 1-bit adder.
        #1;
        set_in(0, 64'd1, 64'd0, 1'b1, 1'b1);
        rst_n  = 1'b1;
        clk_en = 1'b1;
        step("w1 capture");
        check("w1 reg 101", dut_reg[0], 65'h2);
        check("w1 valid after capture", 65'(dut_ov[0]), 65'd1);
        in_v[0] = 1'b0;
        step("w1 hold");
        check("w1 reg held", dut_reg[0], 65'h2);
        check("w1 valid dropped", 65'(dut_ov[0]), 65'd0);

        // 4-bit boundary cases on the combinational path.
        set_in(1, 64'hF, 64'h1, 1'b0, 1'b0);
        #1 check("w4 F+1+0", dut_comb[1], 65'h10);
        set_in(1, 64'hF, 64'hF, 1'b1, 1'b0);
        #1 check("w4 F+F+1", dut_comb[1], 65'h1F);
        set_in(1, 64'h0, 64'h0, 1'b0, 1'b0);
        #1 check("w4 0+0+0", dut_comb[1], 65'h00);
        step("w4 boundary");

        // Back-to-back captures on the 4-bit adder.
        set_in(1, 64'd0, 64'd0, 1'b1, 1'b1);
        step("w4 stream0");
        check("w4 stream0 reg", dut_reg[1], 65'h01);
        check("w4 stream0 valid", 65'(dut_ov[1]), 65'd1);
        set_in(1, 64'd3, 64'd4, 1'b0, 1'b1);
        step("w4 stream1");
        check("w4 stream1 reg", dut_reg[1], 65'h07);
        check("w4 stream1 valid", 65'(dut_ov[1]), 65'd1);
        set_in(1, 64'd8, 64'd8, 1'b1, 1'b1);
        step("w4 stream2");
        check("w4 stream2 reg", dut_reg[1], 65'h11);
        check("w4 stream2 valid", 65'(dut_ov[1]), 65'd1);

        // Asynchronous reset between edges while out_valid is high.
        #2;
        rst_n = 1'b0;
        clear_model();
        #1;
        check("midreset reg w4", dut_reg[1], 65'd0);
        check("midreset valid w4", 65'(dut_ov[1]), 65'd0);
        set_in(1, 64'd5, 64'd6, 1'b1, 1'b1);
        #1;
        check("midreset comb w4", dut_comb[1], 65'h0C);
        compare_all("midreset");
        rst_n = 1'b1;
        step("post reset");
        check("post reset reg w4", dut_reg[1], 65'h0C);

        // Random vectors on all widths, mostly valid.
        for (int k = 0; k < 1000; k++) begin
            for (int i = 0; i < 3; i++) begin
                set_in(i, 64'($urandom()), 64'($urandom()), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) != 0));
            end
            step("random");
        end

        // Maximum operands on the 8-bit adder.
        set_in(2, 64'hFF, 64'hFF, 1'b1, 1'b1);
        step("w8 max");
        check("w8 max reg", dut_reg[2], 65'h1FF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/full_adder_unit.md
Name: full_adder_unit

Overview:
- Ripple-carry binary adder: WIDTH-bit operands a and b plus 1-bit carry-in c produce a WIDTH-bit sum and a carry-out.
- Primary result path is purely combinational. The default WIDTH=1 is a classic 1-bit full adder.
- A registered copy of the result, qualified by a valid strobe, is provided for synchronous consumers in the datapath.

Parameters:
- WIDTH, 1, operand/sum width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock; used by the registered path only.
- rst_n  input  1  asynchronous active-low reset; clears the registered path only.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c  input  1  carry-in.
- in_valid  input  1  qualifies a/b/c for capture into the registered path.
- sum  output  WIDTH  combinational sum, a+b+c modulo 2^WIDTH.
- carry  output  1  combinational carry-out, bit WIDTH of a+b+c.
- sum_q  output  WIDTH  registered sum.
- carry_q  output  1  registered carry-out.
- out_valid  output  1  registered valid; high when sum_q/carry_q hold a newly captured result.

Behaviour:
- Combinational path, zero latency, independent of clk and rst_n:
  - {carry, sum} = a + b + c, evaluated at WIDTH+1 bits.
  - Bit-level structure: chain of WIDTH full-adder cells. Cell i computes s_i = a_i ^ b_i ^ k_i and k_{i+1} = (a_i & b_i) | (k_i & (a_i ^ b_i)), with k_0 = c and carry = k_WIDTH.
  - sum/carry must follow input changes with no clock present and during reset.
  - No X propagation from the registered path into sum/carry.
- 1-bit truth table (a b c -> sum carry):
  - 000->0 0, 001->1 0, 010->1 0, 011->0 1
  - 100->1 0, 101->0 1, 110->0 1, 111->1 1
- Registered path:
  - On rst_n low (asynchronous, immediate): sum_q=0, carry_q=0, out_valid=0.
  - Rising clk with rst_n high and in_valid=1: sum_q<=sum, carry_q<=carry, out_valid<=1. Latency is 1 cycle.
  - Rising clk with in_valid=0: sum_q and carry_q hold their values; out_valid<=0.
  - rst_n deassertion is treated as synchronous to clk by the integrator. The first capture occurs on the first rising edge with rst_n high.
  - Reset asserted mid-stream: the pending capture is discarded, outputs clear at once, and the combinational path is unaffected.
  - Back-to-back in_valid: one result per cycle, no bubbles, no backpressure.
- Width rules:
  - Overflow beyond WIDTH bits appears only on carry; sum wraps modulo 2^WIDTH.
  - Maximum case a = b = 2^WIDTH-1 with c=1 gives sum = all ones and carry=1.

Test Plan:
- WIDTH=1, rst_n=0, no clock: apply the 8 combinations in binary order, 10 time units apart -> sum/carry match the truth table within each interval (e.g. 011 -> sum=0 carry=1; 111 -> sum=1 carry=1).
- WIDTH=1 registered path: release reset, drive a=1 b=0 c=1 with in_valid=1 for one edge -> next cycle sum_q=0 carry_q=1 out_valid=1; following cycle with in_valid=0 -> out_valid=0, sum_q/carry_q held.
- WIDTH=4 boundary: a=4'hF b=4'h1 c=0 -> sum=4'h0 carry=1; a=4'hF b=4'hF c=1 -> sum=4'hF carry=1; a=0 b=0 c=0 -> sum=0 carry=0.
- WIDTH=4 throughput: stream 0+0+1, 3+4+0, 8+8+1 on consecutive edges with in_valid=1 -> sum_q/carry_q = 1/0, 7/0, 1/1 on the following consecutive cycles, out_valid continuously high.
- Reset mid-operation: assert rst_n=0 between clock edges while out_valid=1 -> sum_q, carry_q, out_valid clear immediately; combinational sum/carry still track inputs.
- Random WIDTH=8, 1000 vectors: compare {carry,sum} against a+b+c on the 9-bit combinational result and, one cycle later, on the registered outputs.
